lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator for the data memory ram_2; sits between the execute stage and ram_2.
- Takes one load/store request per transaction and decodes RV32 funct3 into ram_2 access controls.
- Drives ram_2's write-data, write-enable, type, sign, address and read-enable inputs; captures ram_2's read data and misaligned flag.
- Traps misaligned accesses itself and returns one response pulse per request.

Parameters:
- RD_LATENCY, 1: cycles from the clock edge that samples ram_re=1 to valid ram_rdata; legal range 1..3.
- ADDR_W, 32: width of the address bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, already sign- or zero-extended.
- rsp_misaligned  out  1  access trapped as misaligned; qualified by rsp_valid.
- ram_wdat  out  32  to ram_2 write data.
- ram_we  out  1  to ram_2 write enable.
- ram_type  out  4  to ram_2: 0001=byte, 0011=half, 1111=word.
- ram_sign  out  1  to ram_2 sign-extend select.
- ram_addr  out  ADDR_W  to ram_2 address.
- ram_re  out  1  to ram_2 read enable.
- ram_rdata  in  32  from ram_2 data_reg.
- ram_misaligned  in  1  from ram_2 o_memory_address_misaligned.

Behaviour:
- Clock and reset are fixed: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_misaligned=0.
  - ram_we=0, ram_re=0, ram_type=0000, ram_sign=0, ram_addr=0, ram_wdat=0.
- Reset mid-transaction: strobes drop immediately (async) and the transaction is abandoned with no response.
- funct3 decode:
  - 000 → byte, signed load.
  - 001 → half, signed.
  - 010 → word.
  - 100 → byte, unsigned.
  - 101 → half, unsigned.
  - Other values are treated as word, unsigned.
  - Stores ignore the sign bit and drive ram_sign=0.
- Misaligned rule: half with addr[0]=1, or word with addr[1:0]!=00.
- States: IDLE, ISSUE, WAIT, SPLIT_ISSUE, SPLIT_WAIT, RESP.
- IDLE:
  - req_ready=1; accept on req_valid at a clock edge and latch all request fields.
  - Aligned request → ISSUE.
  - Misaligned store → RESP with rsp_misaligned=1 and no RAM strobe.
  - Misaligned load → RESP with rsp_misaligned=1, or → SPLIT_ISSUE when LSU_SPLIT_EN is defined.
- ISSUE (exactly one cycle):
  - Drive ram_addr, ram_type, ram_sign, ram_wdat.
  - Store: ram_we=1 → RESP.
  - Load: ram_re=1 → WAIT.
- WAIT: count RD_LATENCY cycles; on the last one capture ram_rdata → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle → IDLE.
  - rsp_misaligned = trap OR ram_misaligned sampled during ISSUE.
- req_ready=0 in every state except IDLE. There is no response backpressure.
- Latency, counted from the accept edge:
  - Store: rsp_valid in cycle 2.
  - Aligned load: cycle 2+RD_LATENCY.
  - Trap: cycle 1.
- Outside ISSUE/SPLIT_ISSUE, ram_we=ram_re=0. Address, type and data hold their last values.
- A store response returns rsp_rdata=0.

Optional Feature:
- Macro: LSU_SPLIT_EN.
- When defined, a misaligned load is not trapped. Sequence:
  1. SPLIT_ISSUE reads the word at {addr[31:2],00} with ram_type=1111 and ram_sign=0.
  2. SPLIT_WAIT waits RD_LATENCY cycles and captures the low word.
  3. SPLIT_ISSUE and SPLIT_WAIT repeat at +4 and capture the high word.
  4. The LSU extracts bytes {hi,lo} >> (8*addr[1:0]), extends per funct3 itself, then → RESP with rsp_misaligned=0.
- Split latency is 3+2*RD_LATENCY cycles from the accept edge.
- Address +4 wraps modulo 2^ADDR_W.
- Misaligned stores still trap.
- When undefined, the SPLIT states are absent and every misaligned load traps.

Test Plan:
- SW 0x000000c1 to 0x40, then LW from 0x40:
  - Store: one-cycle ram_we with ram_type=1111.
  - Load: rsp_rdata=0x000000c1 at cycle 3 after accept.
- SH 0x0000f0f0 to 0x40, then LH from 0x40 → rsp_rdata=0xfffff0f0. LHU from 0x40 → 0x0000f0f0.
- SB 0xee to 0x42, then LB from 0x42 → 0xffffffee. LBU from 0x42 → 0x000000ee, with ram_type=0001.
- SH to 0x41 → rsp_valid at cycle 1, rsp_misaligned=1, ram_we never asserted.
- LW from 0x41 with memory 0x40=0x44332211 and 0x44=0x88776655:
  - Macro undefined: rsp_misaligned=1.
  - Macro defined: rsp_rdata=0x55443322, two ram_re pulses, at addresses 0x40 and 0x44.
- Load accepted, rst pulsed in the WAIT state: outputs go to reset values at once, no rsp_valid, and the next request completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for the ram_2 data memory.
// Accepts one request at a time, decodes RV32 funct3 into ram_2 access
// controls, issues a single write or read strobe and returns a one-cycle
// response pulse. Misaligned accesses are trapped locally.
//
// Optional feature, macro LSU_SPLIT_EN: when defined, a misaligned load is
// serviced as two aligned word reads (addr & ~3, then +4), and the bytes
// are extracted and extended here. Misaligned stores still trap.
//
// Handshake: a request transfers on a rising clk edge where req_valid=1
// and req_ready=1; req_ready is high only in IDLE. rsp_valid is a single
// cycle pulse with no backpressure; rsp_rdata and rsp_misaligned are only
// meaningful while rsp_valid=1.
module lsu_mem_ctrl #(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_misaligned,
   output logic [31:0]       ram_wdat,
   output logic              ram_we,
   output logic [3:0]        ram_type,
   output logic              ram_sign,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   input  logic [31:0]       ram_rdata,
   input  logic              ram_misaligned
);

   // Access-size encodings understood by ram_2.
   localparam logic [3:0] TYPE_BYTE = 4'b0001;
   localparam logic [3:0] TYPE_HALF = 4'b0011;
   localparam logic [3:0] TYPE_WORD = 4'b1111;

   // Value of the wait counter on the cycle that read data is valid.
   localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3
`ifdef LSU_SPLIT_EN
      ,
      SPLIT_ISSUE = 3'd4,
      SPLIT_WAIT  = 3'd5
`endif
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Latched transaction context.
   logic        we_q;
   logic        mis_q;
   logic [1:0]  cnt;
   logic [31:0] rdata_q;

   // Decoded view of the incoming request.
   logic [3:0]  req_type;
   logic        req_sign;
   logic        req_mis;
   logic        last_beat;

`ifdef LSU_SPLIT_EN
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        hi_phase;
   logic [31:0] lo_q;
   logic [63:0] split_cat;
   logic [31:0] split_shift;
   logic [31:0] split_val;
`endif

   // Decode funct3 into ram_2 size/sign and flag misaligned requests.
   always_comb begin
      req_type = TYPE_WORD;
      req_sign = 1'b0;
      case (req_funct3[1:0])
         2'b00:   req_type = TYPE_BYTE;
         2'b01:   req_type = TYPE_HALF;
         default: req_type = TYPE_WORD;
      endcase
      // Only LB/LH sign-extend; stores never drive the sign select.
      if ((req_funct3 == 3'b000 || req_funct3 == 3'b001) && !req_we)
         req_sign = 1'b1;
      req_mis = ((req_type == TYPE_HALF) && req_addr[0]) ||
                ((req_type == TYPE_WORD) && (req_addr[1:0] != 2'b00));
   end

   assign last_beat = (cnt == LAST_CNT);

`ifdef LSU_SPLIT_EN
   // Reassemble a misaligned load from the two captured words and extend it.
   always_comb begin
      split_cat   = {ram_rdata, lo_q};
      split_shift = 32'(split_cat >> {off_q, 3'b000});
      split_val   = split_shift;
      case (f3_q)
         3'b000:  split_val = {{24{split_shift[7]}}, split_shift[7:0]};
         3'b100:  split_val = {24'h0, split_shift[7:0]};
         3'b001:  split_val = {{16{split_shift[15]}}, split_shift[15:0]};
         3'b101:  split_val = {16'h0, split_shift[15:0]};
         default: split_val = split_shift;
      endcase
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      state_nxt      = state;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      rsp_misaligned = 1'b0;
      ram_we         = 1'b0;
      ram_re         = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!req_mis)    state_nxt = ISSUE;
               else if (req_we) state_nxt = RESP;
               else begin
`ifdef LSU_SPLIT_EN
                  state_nxt = SPLIT_ISSUE;
`else
                  state_nxt = RESP;
`endif
               end
            end
         end
         ISSUE: begin
            ram_we    = we_q;
            ram_re    = !we_q;
            state_nxt = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (last_beat) state_nxt = RESP;
         end
`ifdef LSU_SPLIT_EN
         SPLIT_ISSUE: begin
            ram_re    = 1'b1;
            state_nxt = SPLIT_WAIT;
         end
         SPLIT_WAIT: begin
            if (last_beat) state_nxt = hi_phase ? RESP : SPLIT_ISSUE;
         end
`endif
         RESP: begin
            rsp_valid      = 1'b1;
            rsp_misaligned = mis_q;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_rdata = rdata_q;

   // Request latching, ram_2 control registers and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         mis_q    <= 1'b0;
         cnt      <= 2'd0;
         rdata_q  <= 32'h0;
         ram_addr <= '0;
         ram_type <= 4'b0000;
         ram_sign <= 1'b0;
         ram_wdat <= 32'h0;
`ifdef LSU_SPLIT_EN
         f3_q     <= 3'b000;
         off_q    <= 2'b00;
         hi_phase <= 1'b0;
         lo_q     <= 32'h0;
`endif
      end else begin
`ifdef LSU_SPLIT_EN
         cnt <= (state == WAIT || state == SPLIT_WAIT) ? cnt + 2'd1 : 2'd0;
`else
         cnt <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
`endif
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  mis_q   <= req_mis;
                  rdata_q <= 32'h0;
`ifdef LSU_SPLIT_EN
                  f3_q     <= req_funct3;
                  off_q    <= req_addr[1:0];
                  hi_phase <= 1'b0;
`endif
                  if (!req_mis) begin
                     ram_addr <= req_addr;
                     ram_type <= req_type;
                     ram_sign <= req_sign;
                     if (req_we) ram_wdat <= req_wdata;
                  end
`ifdef LSU_SPLIT_EN
                  else if (!req_we) begin
                     // Split load: two unsigned word reads, no trap.
                     mis_q    <= 1'b0;
                     ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     ram_type <= TYPE_WORD;
                     ram_sign <= 1'b0;
                  end
`endif
               end
            end
            ISSUE: begin
               // ram_2's own misaligned flag is observed during the strobe.
               mis_q <= mis_q | ram_misaligned;
            end
            WAIT: begin
               if (last_beat) rdata_q <= ram_rdata;
            end
`ifdef LSU_SPLIT_EN
            SPLIT_WAIT: begin
               if (last_beat) begin
                  if (!hi_phase) begin
                     lo_q     <= ram_rdata;
                     hi_phase <= 1'b1;
                     ram_addr <= ram_addr + ADDR_W'(4);
                  end else begin
                     rdata_q <= split_val;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural ram_2 model.
// Builds with or without LSU_SPLIT_EN; misaligned-load expectations follow.
module tb_lsu_mem_ctrl;

   localparam int RD_LATENCY = 1;
   localparam int ADDR_W     = 32;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_misaligned;
   logic [31:0]       ram_wdat;
   logic              ram_we;
   logic [3:0]        ram_type;
   logic              ram_sign;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic [31:0]       ram_rdata;
   logic              ram_misaligned;

   int total = 0;
   int bad   = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   lsu_mem_ctrl #(.RD_LATENCY(RD_LATENCY), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
      .ram_wdat(ram_wdat), .ram_we(ram_we), .ram_type(ram_type), .ram_sign(ram_sign),
      .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
      .ram_misaligned(ram_misaligned)
   );

   // ram_2 model: byte memory, registered read with RD_LATENCY stages
   logic [7:0]  mem [256];
   logic [31:0] pipe [RD_LATENCY];
   logic        force_mis;
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [3:0]  we_type = 4'h0;
   logic [3:0]  re_type = 4'h0;
   logic        re_sign = 1'b0;
   logic [31:0] re_addr_prev = 32'h0;
   logic [31:0] re_addr_last = 32'h0;

   assign ram_rdata      = pipe[RD_LATENCY-1];
   assign ram_misaligned = force_mis;

   function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [3:0] t,
                                            input logic s);
      logic [7:0]  base;
      logic [31:0] w;
      logic [31:0] sh;
      base = {a[7:2], 2'b00};
      w    = {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
      sh   = w >> {a[1:0], 3'b000};
      case (t)
         4'b0001: return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
         4'b0011: return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      if (ram_we) begin
         we_cnt  <= we_cnt + 1;
         we_type <= ram_type;
         mem[ram_addr[7:0]] <= ram_wdat[7:0];
         if (ram_type[1]) mem[ram_addr[7:0] + 8'd1] <= ram_wdat[15:8];
         if (ram_type[3]) begin
            mem[ram_addr[7:0] + 8'd2] <= ram_wdat[23:16];
            mem[ram_addr[7:0] + 8'd3] <= ram_wdat[31:24];
         end
      end
      if (ram_re) begin
         re_cnt       <= re_cnt + 1;
         re_type      <= ram_type;
         re_sign      <= ram_sign;
         re_addr_prev <= re_addr_last;
         re_addr_last <= ram_addr;
         pipe[0]      <= ram_read(ram_addr, ram_type, ram_sign);
      end
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
   end

   // comparison helper
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: one request, returns response latency (cycles after accept)
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic mis);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      lat = -1;
      rd  = 32'h0;
      mis = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            rd  = rsp_rdata;
            mis = rsp_misaligned;
            break;
         end
      end
   endtask

   int          lat;
   logic [31:0] rd;
   logic        mis;
   int          we0;
   int          re0;
   int          seen;

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      force_mis  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_ctrl", {22'h0, req_ready, rsp_valid, rsp_misaligned, ram_we, ram_re,
                         ram_sign, ram_type}, {22'h0, 10'b1000000000});
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_addr", ram_addr, 32'h0);
      check("rst_wdat", ram_wdat, 32'h0);

      // SW / LW
      we0 = we_cnt;
      do_req(1'b1, 3'b010, 32'h40, 32'h000000c1, lat, rd, mis);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_rdata", rd, 32'h0);
      check("sw_mis", 32'(mis), 32'd0);
      check("sw_we_pulses", 32'(we_cnt - we0), 32'd1);
      check("sw_type", 32'(we_type), 32'hf);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, mis);
      check("lw_lat", 32'(lat), 32'd3);
      check("lw_rdata", rd, 32'h000000c1);
      check("lw_mis", 32'(mis), 32'd0);

      // SH / LH / LHU
      do_req(1'b1, 3'b001, 32'h40, 32'h0000f0f0, lat, rd, mis);
      check("sh_lat", 32'(lat), 32'd2);
      check("sh_type", 32'(we_type), 32'h3);
      do_req(1'b0, 3'b001, 32'h40, 32'h0, lat, rd, mis);
      check("lh_rdata", rd, 32'hfffff0f0);
      do_req(1'b0, 3'b101, 32'h40, 32'h0, lat, rd, mis);
      check("lhu_rdata", rd, 32'h0000f0f0);

      // SB / LB / LBU
      do_req(1'b1, 3'b000, 32'h42, 32'h000000ee, lat, rd, mis);
      check("sb_type", 32'(we_type), 32'h1);
      do_req(1'b0, 3'b000, 32'h42, 32'h0, lat, rd, mis);
      check("lb_rdata", rd, 32'hffffffee);
      check("lb_sign", 32'(re_sign), 32'd1);
      do_req(1'b0, 3'b100, 32'h42, 32'h0, lat, rd, mis);
      check("lbu_rdata", rd, 32'h000000ee);
      check("lbu_type", 32'(re_type), 32'h1);
      check("lbu_sign", 32'(re_sign), 32'd0);

      // misaligned store traps with no strobe
      we0 = we_cnt;
      do_req(1'b1, 3'b001, 32'h41, 32'h00001234, lat, rd, mis);
      check("sh_mis_lat", 32'(lat), 32'd1);
      check("sh_mis_flag", 32'(mis), 32'd1);
      check("sh_mis_no_we", 32'(we_cnt - we0), 32'd0);

      // preload words for the misaligned load
      do_req(1'b1, 3'b010, 32'h40, 32'h44332211, lat, rd, mis);
      do_req(1'b1, 3'b010, 32'h44, 32'h88776655, lat, rd, mis);

      // funct3 011 behaves as an unsigned word load
      do_req(1'b0, 3'b011, 32'h40, 32'h0, lat, rd, mis);
      check("f3_011_rdata", rd, 32'h44332211);
      check("f3_011_type", 32'(re_type), 32'hf);

      // misaligned word load
      re0 = re_cnt;
      do_req(1'b0, 3'b010, 32'h41, 32'h0, lat, rd, mis);
`ifdef LSU_SPLIT_EN
      check("lw41_lat", 32'(lat), 32'(3 + 2 * RD_LATENCY));
      check("lw41_rdata", rd, 32'h55443322);
      check("lw41_mis", 32'(mis), 32'd0);
      check("lw41_re_pulses", 32'(re_cnt - re0), 32'd2);
      check("lw41_addr_lo", re_addr_prev, 32'h40);
      check("lw41_addr_hi", re_addr_last, 32'h44);
      do_req(1'b0, 3'b001, 32'h43, 32'h0, lat, rd, mis);
      check("lh43_rdata", rd, 32'h00005544);
      check("lh43_mis", 32'(mis), 32'd0);
`else
      check("lw41_lat", 32'(lat), 32'd1);
      check("lw41_mis", 32'(mis), 32'd1);
      check("lw41_no_re", 32'(re_cnt - re0), 32'd0);
      do_req(1'b0, 3'b001, 32'h43, 32'h0, lat, rd, mis);
      check("lh43_mis", 32'(mis), 32'd1);
`endif

      // ram_2 misaligned flag propagates on an aligned access
      force_mis = 1'b1;
      do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, mis);
      force_mis = 1'b0;
      check("rammis_lat", 32'(lat), 32'd3);
      check("rammis_flag", 32'(mis), 32'd1);
      check("rammis_rdata", rd, 32'h44332211);

      // reset pulsed in WAIT abandons the load
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h44;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ctrl", {28'h0, req_ready, rsp_valid, ram_re, ram_we}, 32'h8);
      check("midrst_addr", ram_addr, 32'h0);
      check("midrst_type", 32'(ram_type), 32'h0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("midrst_no_rsp", 32'(seen), 32'd0);
      do_req(1'b0, 3'b010, 32'h44, 32'h0, lat, rd, mis);
      check("post_rst_lat", 32'(lat), 32'd3);
      check("post_rst_rdata", rd, 32'h88776655);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
